sparc_mul_mac_arb: RTL and testbench

- Parametrised successor to the two-client SPARC multiplier top.
- Serves NREQ requesters (EXU, SPU, further units) through one fully pipelined unsigned WIDTH x WIDTH multiplier with a shared accumulator.
- Round-robin issue arbitration, fixed LAT-cycle result latency, and in-order result return tagged with requester ID on a shared output bus.
- Sits in the tile between the requesting units and the datapath, replacing the fixed EXU/SPU priority scheme.

---
 rtl/sparc_mul_mac_arb.sv | 148 ++++++++++++++
 tb/tb_sparc_mul_mac_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_mul_mac_arb.sv
// Shared pipelined unsigned multiplier/accumulator serving NREQ requesters.
// Round-robin issue, fixed-latency in-order results tagged with requester ID.
`timescale 1ns/1ps
module sparc_mul_mac_arb #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 2,
    parameter int LAT   = 5,
    parameter int ACC_W = 2*WIDTH+8,
    parameter int IDW   = 3
) (
    input  logic                  rclk,
    input  logic                  rst_l,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [2*NREQ-1:0]     req_mode,
    input  logic [WIDTH*NREQ-1:0] req_op1,
    input  logic [WIDTH*NREQ-1:0] req_op2,
    input  logic                  acc_clr,
    output logic [NREQ-1:0]       req_gnt,
    output logic                  mul_out_vld,
    output logic [IDW-1:0]        mul_out_id,
    output logic [WIDTH-1:0]      mul_data_out
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] MODE_MULL = 2'b00;
    localparam logic [1:0] MODE_MULH = 2'b01;
    localparam logic [1:0] MODE_MAC  = 2'b10;

    logic [PW-1:0]      r_ptr;
    logic [ACC_W-1:0]   r_acc;
    logic [WIDTH-1:0]   r_dataHold;

    logic               r_vld  [1:LAT];
    logic [IDW-1:0]     r_id   [1:LAT];
    logic [1:0]         r_mode [1:LAT];
    logic [2*WIDTH-1:0] r_prod [1:LAT];

    logic [WIDTH-1:0]   w_op1  [NREQ];
    logic [WIDTH-1:0]   w_op2  [NREQ];
    logic [1:0]         w_mode [NREQ];

    logic [NREQ-1:0]    w_gnt;
    logic               w_gntAny;
    logic [PW-1:0]      w_gntIdx;
    logic [PW-1:0]      w_cand;

    logic [ACC_W-1:0]   w_accBase;
    logic [ACC_W-1:0]   w_accSum;
    logic [ACC_W-1:0]   w_accNext;
    logic [WIDTH-1:0]   w_result;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_op1[g]  = req_op1[g*WIDTH +: WIDTH];
        assign w_op2[g]  = req_op2[g*WIDTH +: WIDTH];
        assign w_mode[g] = req_mode[2*g +: 2];
    end

    // Scan requesters cyclically from the pointer; the first one asking wins.
    always_comb begin
        w_gnt    = '0;
        w_gntAny = 1'b0;
        w_gntIdx = '0;
        w_cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % NREQ);
            if (!w_gntAny && req_vld[w_cand]) begin
                w_gnt[w_cand] = 1'b1;
                w_gntAny      = 1'b1;
                w_gntIdx      = w_cand;
            end
        end
        if (!rst_l) begin
            w_gnt    = '0;
            w_gntAny = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            r_ptr <= '0;
        end else if (w_gntAny) begin
            r_ptr <= (w_gntIdx == PW'(NREQ-1)) ? '0 : w_gntIdx + 1'b1;
        end
    end

    // Product is formed in stage 1 and carried down; retiming may spread it.
    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            for (int s = 1; s <= LAT; s++) begin
                r_vld[s]  <= 1'b0;
                r_id[s]   <= '0;
                r_mode[s] <= '0;
                r_prod[s] <= '0;
            end
        end else begin
            r_vld[1]  <= w_gntAny;
            r_id[1]   <= IDW'(w_gntIdx);
            r_mode[1] <= w_mode[w_gntIdx];
            r_prod[1] <= (2*WIDTH)'(w_op1[w_gntIdx]) * (2*WIDTH)'(w_op2[w_gntIdx]);
            for (int s = 2; s <= LAT; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_id[s]   <= r_id[s-1];
                r_mode[s] <= r_mode[s-1];
                r_prod[s] <= r_prod[s-1];
            end
        end
    end

    // Final stage: acc_clr acts before this cycle's MAC/SHF sees the accumulator.
    always_comb begin
        w_accBase = acc_clr ? '0 : r_acc;
        w_accSum  = w_accBase + ACC_W'(r_prod[LAT]);
        w_accNext = w_accBase;
        w_result  = '0;
        if (r_vld[LAT]) begin
            case (r_mode[LAT])
                MODE_MULL: w_result = r_prod[LAT][WIDTH-1:0];
                MODE_MULH: w_result = r_prod[LAT][2*WIDTH-1:WIDTH];
                MODE_MAC: begin
                    w_accNext = w_accSum;
                    w_result  = w_accSum[WIDTH-1:0];
                end
                default: begin
                    w_result  = w_accBase[WIDTH-1:0];
                    w_accNext = w_accBase >> WIDTH;
                end
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            r_acc      <= '0;
            r_dataHold <= '0;
        end else begin
            r_acc <= w_accNext;
            if (r_vld[LAT]) begin
                r_dataHold <= w_result;
            end
        end
    end

    assign req_gnt      = w_gnt;
    assign mul_out_vld  = r_vld[LAT] & rst_l;
    assign mul_out_id   = r_id[LAT];
    assign mul_data_out = mul_out_vld ? w_result : r_dataHold;

endmodule

// File: tb/tb_sparc_mul_mac_arb.sv
// Directed bench for sparc_mul_mac_arb: expected results are queued at grant
// time from a small arithmetic model and checked when the result emerges.
`timescale 1ns/1ps
module tb_sparc_mul_mac_arb;

    localparam int LAT = 5;
    localparam logic [1:0] MULL = 2'b00;
    localparam logic [1:0] MULH = 2'b01;
    localparam logic [1:0] MAC  = 2'b10;
    localparam logic [1:0] SHF  = 2'b11;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] BIT63 = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [2:0]  id;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic         rclk = 1'b0;
    logic         rst_l;
    logic [1:0]   req_vld;
    logic [3:0]   req_mode;
    logic [127:0] req_op1;
    logic [127:0] req_op2;
    logic         acc_clr;
    logic [1:0]   req_gnt;
    logic         mul_out_vld;
    logic [2:0]   mul_out_id;
    logic [63:0]  mul_data_out;

    int           checkCount = 0;
    int           passCount  = 0;
    int           failCount  = 0;
    int           cycle      = 0;
    bit           monEnable  = 1'b0;
    logic [63:0]  lastData   = '0;
    logic [135:0] mAcc       = '0;
    int           mPtr       = 0;
    exp_t         sbQ[$];
    exp_t         monEntry;

    sparc_mul_mac_arb #(.WIDTH(64), .NREQ(2), .LAT(LAT), .IDW(3)) dut (
        .rclk         (rclk),
        .rst_l        (rst_l),
        .req_vld      (req_vld),
        .req_mode     (req_mode),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .acc_clr      (acc_clr),
        .req_gnt      (req_gnt),
        .mul_out_vld  (mul_out_vld),
        .mul_out_id   (mul_out_id),
        .mul_data_out (mul_data_out)
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) cycle++;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] predict(input logic [1:0] mode, input logic [63:0] a,
                                            input logic [63:0] b, input logic clrFirst);
        logic [127:0] p;
        logic [63:0]  r;
        p = {64'b0, a} * {64'b0, b};
        if (clrFirst) mAcc = '0;
        case (mode)
            MULL: r = p[63:0];
            MULH: r = p[127:64];
            MAC: begin
                mAcc = mAcc + {8'b0, p};
                r    = mAcc[63:0];
            end
            default: begin
                r    = mAcc[63:0];
                mAcc = mAcc >> 64;
            end
        endcase
        return r;
    endfunction

    function automatic int expGrantIdx(input logic [1:0] vld);
        for (int k = 0; k < 2; k++) begin
            if (vld[(mPtr + k) % 2]) return (mPtr + k) % 2;
        end
        return -1;
    endfunction

    // One cycle of stimulus: drive, check the grant, queue the expected result.
    task automatic applyStimulus(input logic [1:0] vld,
                                 input logic [1:0] m0, input logic [63:0] a0, input logic [63:0] b0,
                                 input logic [1:0] m1, input logic [63:0] a1, input logic [63:0] b1,
                                 input logic clr, input logic clrAtFinal);
        int         g;
        logic [1:0] expG;
        exp_t       e;
        req_vld  = vld;
        req_mode = {m1, m0};
        req_op1  = {a1, a0};
        req_op2  = {b1, b0};
        acc_clr  = clr;
        g = expGrantIdx(vld);
        expG = (g < 0) ? 2'b00 : 2'(1 << g);
        @(negedge rclk);
        checkOutput("req_gnt", req_gnt, expG);
        if (g >= 0) begin
            e.id   = 3'(g);
            e.data = (g == 0) ? predict(m0, a0, b0, clrAtFinal) : predict(m1, a1, b1, clrAtFinal);
            e.cyc  = cycle + LAT;
            sbQ.push_back(e);
            mPtr = (g + 1) % 2;
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(2'b00, MULL, 0, 0, MULL, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic issue0(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b, input logic clrAtFinal);
        applyStimulus(2'b01, m, a, b, MULL, 0, 0, 1'b0, clrAtFinal);
    endtask

    task automatic issue1(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
        applyStimulus(2'b10, MULL, 0, 0, m, a, b, 1'b0, 1'b0);
    endtask

    task automatic issueBoth(input logic [1:0] m0, input logic [63:0] a0, input logic [63:0] b0,
                             input logic [1:0] m1, input logic [63:0] a1, input logic [63:0] b1);
        applyStimulus(2'b11, m0, a0, b0, m1, a1, b1, 1'b0, 1'b0);
    endtask

    // Clear with the pipeline drained so the model can clear in issue order.
    task automatic clearAcc();
        idle(LAT + 1);
        applyStimulus(2'b00, MULL, 0, 0, MULL, 0, 0, 1'b1, 1'b0);
        mAcc = '0;
    endtask

    always @(negedge rclk) begin
        if (monEnable && rst_l === 1'b1) begin
            if (mul_out_vld === 1'b1) begin
                checkOutput("vld_expected", 128'(sbQ.size() != 0), 128'd1);
                if (sbQ.size() != 0) begin
                    monEntry = sbQ.pop_front();
                    checkOutput("out_id", mul_out_id, monEntry.id);
                    checkOutput("out_data", mul_data_out, monEntry.data);
                    checkOutput("out_cycle", 128'(cycle), 128'(monEntry.cyc));
                    lastData = monEntry.data;
                end
            end else begin
                checkOutput("vld_low", mul_out_vld, 1'b0);
                checkOutput("data_hold", mul_data_out, lastData);
            end
        end
    end

    initial begin
        rst_l    = 1'b0;
        req_vld  = '0;
        req_mode = '0;
        req_op1  = '0;
        req_op2  = '0;
        acc_clr  = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        req_vld = 2'b11;
        @(negedge rclk);
        checkOutput("rst_gnt", req_gnt, 2'b00);
        checkOutput("rst_vld", mul_out_vld, 1'b0);
        checkOutput("rst_id", mul_out_id, 3'd0);
        checkOutput("rst_data", mul_data_out, 64'd0);
        @(posedge rclk);
        #1;
        rst_l     = 1'b1;
        req_vld   = '0;
        monEnable = 1'b1;

        idle(3);
        issue0(MULL, 64'h3, 64'h5, 1'b0);
        idle(LAT + 2);
        issue1(MULL, 64'd7, 64'd9);

        issueBoth(MULL, 64'd2, 64'd3, MULL, 64'd4, 64'd5);
        issueBoth(MULL, 64'd6, 64'd7, MULH, BIT63, 64'd4);
        issueBoth(MULH, ONES, 64'd2, MULL, 64'd11, 64'd13);
        issueBoth(MULL, 64'd100, 64'd100, MULL, ONES, 64'd3);
        idle(LAT + 1);

        issue0(MULH, ONES, ONES, 1'b0);
        issue1(MULL, ONES, ONES);

        clearAcc();
        issue0(MAC, BIT63, 64'd4, 1'b0);
        issue0(MAC, BIT63, 64'd4, 1'b0);
        issue0(SHF, 64'hDEAD, 64'hBEEF, 1'b0);
        issue0(SHF, 64'h1234, 64'h5678, 1'b0);
        issue0(MULL, 64'd1, 64'd1, 1'b0);
        issue0(SHF, 64'd9, 64'd9, 1'b0);
        idle(LAT + 1);

        clearAcc();
        issue0(MAC, 64'd10, 64'd10, 1'b0);
        idle(2);
        issue0(MAC, 64'd7, 64'd6, 1'b1);
        idle(LAT - 1);
        applyStimulus(2'b00, MULL, 0, 0, MULL, 0, 0, 1'b1, 1'b0);
        issue0(SHF, 64'd0, 64'd0, 1'b0);
        idle(LAT + 1);

        clearAcc();
        issue0(MAC, 64'd3, 64'd3, 1'b0);
        idle(LAT + 1);
        issue0(MAC, 64'd5, 64'd5, 1'b0);
        issue1(MULL, 64'd2, 64'd2);
        issue0(MULL, 64'd3, 64'd3, 1'b0);
        rst_l   = 1'b0;
        req_vld = 2'b11;
        @(negedge rclk);
        checkOutput("midrst_gnt", req_gnt, 2'b00);
        checkOutput("midrst_vld", mul_out_vld, 1'b0);
        sbQ.delete();
        mPtr = 0;
        mAcc = '0;
        @(posedge rclk);
        #1;
        rst_l    = 1'b1;
        req_vld  = '0;
        lastData = '0;
        idle(10);
        issueBoth(SHF, 64'd1, 64'd1, MULL, 64'd8, 64'd8);
        issue1(MULL, 64'd8, 64'd8);
        idle(LAT + 2);

        checkOutput("sb_drained", 128'(sbQ.size()), 128'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
